// File: rtl/pm_load_sequencer_pkg.sv
// Shared types and width helpers for the program-memory load sequencer.
package pm_load_sequencer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADD_WIDTH  = 7;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned BYTES          = DEF_DATA_WIDTH / DEF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned data_width,
                                                 input int unsigned width);
    return data_width / width;
  endfunction

  // The byte counter keeps at least one bit even when a word is a single byte.
  function automatic int unsigned byte_cnt_width(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/pm_load_sequencer_if.sv
// Pad-byte input, fetch address and program-memory write port of the load sequencer.
interface pm_load_sequencer_if
  import pm_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int unsigned WIDTH      = DEF_WIDTH
);

  logic [WIDTH-1:0]      byte_in;
  logic                  byte_valid;
  logic [ADD_WIDTH-1:0]  cpu_fetch_addr;
  logic                  pm_wr_en;
  logic [ADD_WIDTH-1:0]  pm_addr;
  logic [DATA_WIDTH-1:0] pm_wdata;

  // master = the sequencer, which owns the program-memory port
  modport master (
    input  byte_in, byte_valid, cpu_fetch_addr,
    output pm_wr_en, pm_addr, pm_wdata
  );

  modport slave (
    output byte_in, byte_valid, cpu_fetch_addr,
    input  pm_wr_en, pm_addr, pm_wdata
  );

endinterface

// File: rtl/pm_load_sequencer_byte_packer.sv
// Assembles little-endian pad bytes into instruction words; emits a one-cycle word_valid.
module pm_load_sequencer_byte_packer
  import pm_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [WIDTH-1:0]      i_byte,
  output logic                  o_partial,
  output logic                  o_word_valid,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam int unsigned N_BYTES = bytes_per_word(DATA_WIDTH, WIDTH);
  localparam int unsigned CNT_W   = byte_cnt_width(N_BYTES);

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_word_valid;
  logic [DATA_WIDTH-1:0] w_insert;
  logic                  w_last;

  // Drop the incoming byte into the lane selected by the byte counter.
  genvar gi;
  generate
    for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
      assign w_insert[gi*WIDTH +: WIDTH] =
        (r_cnt == CNT_W'(gi)) ? i_byte : r_shift[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_last = (r_cnt == CNT_W'(N_BYTES - 1));

  // The finished word lives in its own register so the next word can start
  // filling r_shift during the write cycle without disturbing pm_wdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_accept) begin
        if (w_last) begin
          r_word       <= w_insert;
          r_word_valid <= 1'b1;
          r_cnt        <= '0;
        end else begin
          r_shift <= w_insert;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_partial    = (r_cnt != '0);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/pm_load_sequencer.sv
// Program-memory loader and CPU run control: run-state FSM, load address, sticky flags, pm_addr mux.
module pm_load_sequencer
  import pm_load_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int unsigned WIDTH      = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pm_load_sequencer_if.master  bus,
  input  logic                 i_cmd_load,
  input  logic                 i_cmd_run,
  input  logic                 i_cmd_halt,
  output logic                 o_cpu_rst_n,
  output logic                 o_cpu_stall,
  output logic [1:0]           o_state,
  output logic [ADD_WIDTH:0]   o_words_loaded,
  output logic                 o_err_partial,
  output logic                 o_mem_full
);

  localparam logic [ADD_WIDTH-1:0] LAST_ADDR = '1;

  seq_state_e            r_state;
  seq_state_e            w_state_next;
  logic [ADD_WIDTH-1:0]  r_load_addr;
  logic [ADD_WIDTH:0]    r_words_loaded;
  logic                  r_err_partial;
  logic                  r_mem_full;
  logic                  r_cpu_rst_n;
  logic                  r_cpu_stall;

  logic                  w_do_halt;
  logic                  w_do_load;
  logic                  w_do_run;
  logic                  w_wr_en;
  logic                  w_last_write;
  logic                  w_partial;
  logic                  w_clear;
  logic                  w_accept;
  logic                  w_leave_partial;
  logic [DATA_WIDTH-1:0] w_word;

  // Halt outranks load outranks run; an ignored halt in IDLE does not mask the others.
  assign w_do_halt    = i_cmd_halt && (r_state != ST_IDLE);
  assign w_do_load    = !w_do_halt && i_cmd_load;
  assign w_do_run     = !w_do_halt && !i_cmd_load && i_cmd_run;
  assign w_last_write = w_wr_en && (r_load_addr == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_do_halt) begin
      w_state_next = ST_HALT;
    end else if (w_do_load) begin
      w_state_next = ST_LOAD;
    end else if (w_do_run) begin
      w_state_next = ST_RUN;
    end else if (w_last_write) begin
      w_state_next = ST_IDLE;
    end
  end

  // Bytes count only while LOAD continues uninterrupted into the next cycle.
  assign w_clear         = (w_state_next != ST_LOAD) || w_do_load;
  assign w_accept        = bus.byte_valid && (r_state == ST_LOAD) && !w_clear;
  assign w_leave_partial = (r_state == ST_LOAD) && (w_state_next != ST_LOAD) && w_partial;

  pm_load_sequencer_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIDTH      (WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_accept     (w_accept),
    .i_byte       (bus.byte_in),
    .o_partial    (w_partial),
    .o_word_valid (w_wr_en),
    .o_word       (w_word)
  );

  // The write cycle always finishes at the current address; a concurrent
  // cmd_load only redirects what happens after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_addr    <= '0;
      r_words_loaded <= '0;
      r_err_partial  <= 1'b0;
      r_mem_full     <= 1'b0;
      r_cpu_rst_n    <= 1'b0;
      r_cpu_stall    <= 1'b0;
    end else begin
      r_cpu_rst_n <= (w_state_next == ST_RUN) || (w_state_next == ST_HALT);
      r_cpu_stall <= (w_state_next == ST_HALT);
      if (w_do_load) begin
        r_load_addr    <= '0;
        r_words_loaded <= '0;
        r_err_partial  <= 1'b0;
        r_mem_full     <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_load_addr    <= r_load_addr + 1'b1;
          r_words_loaded <= r_words_loaded + 1'b1;
          if (w_last_write) begin
            r_mem_full <= 1'b1;
          end
        end
        if (w_leave_partial) begin
          r_err_partial <= 1'b1;
        end
      end
    end
  end

  assign bus.pm_addr  = ((r_state == ST_RUN) || (r_state == ST_HALT)) ?
                        bus.cpu_fetch_addr : r_load_addr;
  assign bus.pm_wr_en = w_wr_en;
  assign bus.pm_wdata = w_word;

  assign o_cpu_rst_n    = r_cpu_rst_n;
  assign o_cpu_stall    = r_cpu_stall;
  assign o_state        = r_state;
  assign o_words_loaded = r_words_loaded;
  assign o_err_partial  = r_err_partial;
  assign o_mem_full     = r_mem_full;

endmodule

// File: tb/tb_pm_load_sequencer.sv
// Directed scoreboard bench: stimulus queues expected writes/status, a negedge monitor compares.
module tb_pm_load_sequencer;
  import pm_load_sequencer_pkg::*;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int W  = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    string         name;
    logic [1:0]    st;
    logic          rstn;
    logic          stall;
    logic [AW:0]   words;
    logic          err;
    logic          full;
    logic [AW-1:0] addr;
    logic          chk_wdata;
    logic [DW-1:0] wdata;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_load, cmd_run, cmd_halt;
  logic          cpu_rst_n, cpu_stall, err_partial, mem_full;
  logic [1:0]    state;
  logic [AW:0]   words_loaded;

  wr_t   wq[$];
  stat_t sq[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    done_req = 1'b0;
  bit    mon_done = 1'b0;

  pm_load_sequencer_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .WIDTH(W)) bus ();

  pm_load_sequencer #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .i_cmd_load     (cmd_load),
    .i_cmd_run      (cmd_run),
    .i_cmd_halt     (cmd_halt),
    .o_cpu_rst_n    (cpu_rst_n),
    .o_cpu_stall    (cpu_stall),
    .o_state        (state),
    .o_words_loaded (words_loaded),
    .o_err_partial  (err_partial),
    .o_mem_full     (mem_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, exp);
    end
  endtask

  // Monitor: compares every write strobe and any queued status snapshot.
  always @(negedge clk) begin
    if (bus.pm_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.pm_addr, bus.pm_wdata);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("write", "pm_addr", 64'(bus.pm_addr), 64'(w.addr));
        chk("write", "pm_wdata", 64'(bus.pm_wdata), 64'(w.data));
        $display("write addr=0x%0h data=0x%08h", bus.pm_addr, bus.pm_wdata);
      end
    end
    if (sq.size() != 0) begin
      stat_t s;
      s = sq.pop_front();
      chk(s.name, "state", 64'(state), 64'(s.st));
      chk(s.name, "cpu_rst_n", 64'(cpu_rst_n), 64'(s.rstn));
      chk(s.name, "cpu_stall", 64'(cpu_stall), 64'(s.stall));
      chk(s.name, "words_loaded", 64'(words_loaded), 64'(s.words));
      chk(s.name, "err_partial", 64'(err_partial), 64'(s.err));
      chk(s.name, "mem_full", 64'(mem_full), 64'(s.full));
      chk(s.name, "pm_addr", 64'(bus.pm_addr), 64'(s.addr));
      chk(s.name, "pm_wr_en", 64'(bus.pm_wr_en), 64'(0));
      if (s.chk_wdata) chk(s.name, "pm_wdata", 64'(bus.pm_wdata), 64'(s.wdata));
      $display("status %s state=%0d words=%0d err=%0b full=%0b pm_addr=0x%0h",
               s.name, state, words_loaded, err_partial, mem_full, bus.pm_addr);
    end
    if (done_req && !mon_done) begin
      chk("drain", "pending_writes", 64'(wq.size()), 64'(0));
      mon_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_status(input string name, input logic [1:0] st, input logic rstn,
                            input logic stall, input logic [AW:0] words, input logic err,
                            input logic full, input logic [AW-1:0] addr,
                            input logic chk_wdata, input logic [DW-1:0] wdata);
    stat_t s;
    s.name = name; s.st = st; s.rstn = rstn; s.stall = stall; s.words = words;
    s.err = err; s.full = full; s.addr = addr; s.chk_wdata = chk_wdata; s.wdata = wdata;
    sq.push_back(s);
  endtask

  task automatic exp_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wq.push_back(w);
  endtask

  // One byte per high cycle, optionally followed by idle gap cycles.
  task automatic send_word(input logic [DW-1:0] word, input int gap);
    for (int k = 0; k < BYTES; k++) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = word[k*W +: W];
      tick();
      bus.byte_valid = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    return {8'(k), 8'(8'd255 - 8'(k)), 8'h5A, 8'(k + 1)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_load = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.cpu_fetch_addr = 7'h15;

    tick();
    exp_status("reset", 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b1, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Two real instructions with idle gaps between bytes.
    cmd_load = 1'b1; tick(); cmd_load = 1'b0;
    exp_status("load_entry", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);
    exp_write(7'd0, 32'h00500093);
    exp_write(7'd1, 32'h00100113);
    send_word(32'h00500093, 1);
    send_word(32'h00100113, 1);
    exp_status("two_words", 2'd1, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 7'd2, 1'b0, 32'h0);

    // byte_valid held high across the word boundary; cmd_load lands in the last write cycle.
    tick();
    cmd_load = 1'b1; tick(); cmd_load = 1'b0;
    exp_status("restart", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);
    exp_write(7'd0, 32'hDEADBEEF);
    exp_write(7'd1, 32'h12345678);
    send_word(32'hDEADBEEF, 0);
    send_word(32'h12345678, 0);
    cmd_load = 1'b1; tick(); cmd_load = 1'b0;
    exp_status("load_in_wr_cycle", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);

    // Three bytes then cmd_run: partial word dropped.
    tick();
    bus.byte_valid = 1'b1; bus.byte_in = 8'h11; tick();
    bus.byte_in = 8'h22; tick();
    bus.byte_in = 8'h33; tick();
    bus.byte_valid = 1'b0;
    exp_status("three_bytes", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    exp_status("partial_run", 2'd2, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 7'h15, 1'b0, 32'h0);
    tick();

    // All three commands at once in RUN: halt wins.
    cmd_halt = 1'b1; cmd_load = 1'b1; cmd_run = 1'b1; tick();
    cmd_halt = 1'b0; cmd_load = 1'b0; cmd_run = 1'b0;
    exp_status("halt_prio", 2'd3, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 7'h15, 1'b0, 32'h0);
    tick();
    bus.cpu_fetch_addr = 7'h2A;
    exp_status("halt_fetch", 2'd3, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 7'h2A, 1'b0, 32'h0);
    tick();
    cmd_run = 1'b1; tick(); cmd_run = 1'b0;
    exp_status("halt_to_run", 2'd2, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 7'h2A, 1'b0, 32'h0);

    // Fill all 128 words back to back.
    tick();
    cmd_load = 1'b1; tick(); cmd_load = 1'b0;
    exp_status("load_from_run", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);
    for (int k = 0; k < 128; k++) begin
      exp_write(7'(k), pat(k));
      send_word(pat(k), 0);
    end
    tick();
    exp_status("full", 2'd0, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 7'd0, 1'b0, 32'h0);
    send_word(32'hA1B2C3D4, 0);
    tick();
    exp_status("idle_ignores", 2'd0, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 7'd0, 1'b1, pat(127));

    // Asynchronous reset after two bytes of a word.
    tick();
    cmd_load = 1'b1; tick(); cmd_load = 1'b0;
    exp_status("reload", 2'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'h0);
    bus.byte_valid = 1'b1; bus.byte_in = 8'hAB; tick();
    bus.byte_in = 8'hCD; tick();
    bus.byte_in = 8'hEF;
    rst_n = 1'b0;
    exp_status("async_reset", 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b1, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    tick();
    exp_status("post_reset", 2'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 7'd0, 1'b1, 32'h0);
    tick();

    done_req = 1'b1;
    for (int i = 0; i < 4 && !mon_done; i++) @(negedge clk);
    #1;
    if (!mon_done) begin
      $display("FAIL drain_timeout: got monitor idle, expected drain within 4 cycles");
      $fatal(1, "drain timeout");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
